// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Fetch / data-stage arbiter onto one fixed-latency memory port.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [63:0] if_rdata,
    input  logic        dm_req,
    input  logic [31:0] dm_addr,
    input  logic [7:0]  dm_w_mask,
    input  logic [63:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_done,
    output logic [63:0] dm_rdata,
    output logic        mem_cs,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_w_mask,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] c_LAT_LOAD = 4'(MEM_LAT - 1);
    localparam logic       c_OWN_IF   = 1'b0;
    localparam logic       c_OWN_DM   = 1'b1;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_owner;
    logic       w_owner_nxt;
    logic       r_write;
    logic       w_write_nxt;
    logic       r_last_win;
    logic       w_last_win_nxt;

    logic       w_complete;
    logic       w_arb_ok;
    logic       w_contend;
    logic       w_dm_wins;

    // The completion cycle doubles as an IDLE cycle so grants can go back-to-back.
    assign w_complete = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_arb_ok   = !rst && ((r_state == S_IDLE) || w_complete);
    assign w_contend  = if_req && dm_req;
    assign w_dm_wins  = dm_req && (!if_req || (r_last_win == c_OWN_IF));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_owner    <= c_OWN_IF;
            r_write    <= 1'b0;
            r_last_win <= c_OWN_IF;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_owner    <= w_owner_nxt;
            r_write    <= w_write_nxt;
            r_last_win <= w_last_win_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_owner_nxt    = r_owner;
        w_write_nxt    = r_write;
        w_last_win_nxt = r_last_win;
        if_gnt         = 1'b0;
        dm_gnt         = 1'b0;
        if_rvalid      = 1'b0;
        dm_done        = 1'b0;
        mem_cs         = 1'b0;
        mem_addr       = 32'd0;
        mem_w_mask     = 8'd0;
        mem_wdata      = 64'd0;

        if (!rst && w_complete) begin
            if_rvalid   = (r_owner == c_OWN_IF);
            dm_done     = (r_owner == c_OWN_DM);
            w_state_nxt = S_IDLE;
        end else if (r_state == S_WAIT) begin
            w_cnt_nxt = r_cnt - 4'd1;
        end

        if (w_arb_ok && (if_req || dm_req)) begin
            mem_cs      = 1'b1;
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_LAT_LOAD;
            if (w_dm_wins) begin
                dm_gnt      = 1'b1;
                mem_addr    = dm_addr;
                mem_w_mask  = dm_w_mask;
                mem_wdata   = dm_wdata;
                w_owner_nxt = c_OWN_DM;
                w_write_nxt = |dm_w_mask;
            end else begin
                if_gnt      = 1'b1;
                mem_addr    = if_addr;
                w_owner_nxt = c_OWN_IF;
                w_write_nxt = 1'b0;
            end
            // Only contended grants steer the alternation.
            if (w_contend) begin
                w_last_win_nxt = w_dm_wins ? c_OWN_DM : c_OWN_IF;
            end
        end
    end

    assign if_rdata = if_rvalid ? mem_rdata : 64'd0;
    assign dm_rdata = (dm_done && !r_write) ? mem_rdata : 64'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: scoreboard bench; main DUT at MEM_LAT=2, second DUT at MEM_LAT=1.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    logic stim_done = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A (MEM_LAT=2)
    logic        a_if_req = 1'b0, a_dm_req = 1'b0;
    logic [31:0] a_if_addr = '0, a_dm_addr = '0;
    logic [7:0]  a_dm_w_mask = '0;
    logic [63:0] a_dm_wdata = '0;
    logic        a_if_gnt, a_if_rvalid, a_dm_gnt, a_dm_done, a_mem_cs;
    logic [63:0] a_if_rdata, a_dm_rdata, a_mem_wdata, a_mem_rdata;
    logic [31:0] a_mem_addr;
    logic [7:0]  a_mem_w_mask;

    // DUT B (MEM_LAT=1), fetch only
    logic        b_if_req = 1'b0, b_dm_req = 1'b0;
    logic [31:0] b_if_addr = '0, b_dm_addr = '0;
    logic [7:0]  b_dm_w_mask = '0;
    logic [63:0] b_dm_wdata = '0;
    logic        b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_done, b_mem_cs;
    logic [63:0] b_if_rdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;
    logic [31:0] b_mem_addr;
    logic [7:0]  b_mem_w_mask;

    mem_arbiter #(.MEM_LAT(2)) u_dut_a (
        .clk(clk), .rst(rst),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .dm_req(a_dm_req), .dm_addr(a_dm_addr), .dm_w_mask(a_dm_w_mask),
        .dm_wdata(a_dm_wdata), .dm_gnt(a_dm_gnt), .dm_done(a_dm_done),
        .dm_rdata(a_dm_rdata),
        .mem_cs(a_mem_cs), .mem_addr(a_mem_addr), .mem_w_mask(a_mem_w_mask),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    mem_arbiter #(.MEM_LAT(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_addr(b_dm_addr), .dm_w_mask(b_dm_w_mask),
        .dm_wdata(b_dm_wdata), .dm_gnt(b_dm_gnt), .dm_done(b_dm_done),
        .dm_rdata(b_dm_rdata),
        .mem_cs(b_mem_cs), .mem_addr(b_mem_addr), .mem_w_mask(b_mem_w_mask),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    function automatic logic [63:0] memval(input logic [31:0] a);
        if (a == 32'h0000_0100) return 64'hDEAD_BEEF_0000_0013;
        return {~a, a};
    endfunction

    // Memory responder: returns data for the most recently issued address.
    logic [31:0] pend_a = '0, pend_b = '0;
    always @(posedge clk) begin
        if (a_mem_cs) pend_a <= a_mem_addr;
        if (b_mem_cs) pend_b <= b_mem_addr;
    end
    assign a_mem_rdata = memval(pend_a);
    assign b_mem_rdata = memval(pend_b);

    typedef struct {
        int          cyc;
        bit          dm;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [63:0] wdata;
    } gnt_t;
    typedef struct {
        int          cyc;
        bit          dm;
        bit          chk;
        logic [63:0] data;
    } done_t;

    gnt_t  gq[$];
    done_t cq[$];
    gnt_t  bgq[$];
    done_t bcq[$];

    task automatic exp_gnt(input int c, input bit dm, input logic [31:0] ad,
                           input logic [7:0] m, input logic [63:0] wd);
        gq.push_back('{c, dm, ad, m, wd});
    endtask
    task automatic exp_done(input int c, input bit dm, input bit chk, input logic [63:0] d);
        cq.push_back('{c, dm, chk, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        gnt_t  g;
        done_t d;
        logic [63:0] rd;
        while (gq.size() > 0 && gq[0].cyc < cyc) begin
            g = gq.pop_front(); tests++; fails++;
            $display("FAIL a_grant_missing: no grant observed, required dm=%0d addr=%h at cycle %0d", g.dm, g.addr, g.cyc);
        end
        while (cq.size() > 0 && cq[0].cyc < cyc) begin
            d = cq.pop_front(); tests++; fails++;
            $display("FAIL a_done_missing: no completion observed, required dm=%0d at cycle %0d", d.dm, d.cyc);
        end
        while (bgq.size() > 0 && bgq[0].cyc < cyc) begin
            g = bgq.pop_front(); tests++; fails++;
            $display("FAIL b_grant_missing: no fetch grant observed, required addr=%h at cycle %0d", g.addr, g.cyc);
        end
        while (bcq.size() > 0 && bcq[0].cyc < cyc) begin
            d = bcq.pop_front(); tests++; fails++;
            $display("FAIL b_done_missing: no completion observed, required at cycle %0d", d.cyc);
        end

        if (rst) begin
            tests++;
            if ({a_if_gnt, a_dm_gnt, a_if_rvalid, a_dm_done, a_mem_cs,
                 b_if_gnt, b_if_rvalid, b_mem_cs} != 8'd0 ||
                a_mem_addr != 32'd0 || a_mem_w_mask != 8'd0 || a_mem_wdata != 64'd0) begin
                fails++;
                $display("FAIL reset_outputs: cyc=%0d ctl=%b addr=%h mask=%h wdata=%h, required all zero",
                         cyc, {a_if_gnt, a_dm_gnt, a_if_rvalid, a_dm_done, a_mem_cs, b_if_gnt, b_if_rvalid, b_mem_cs},
                         a_mem_addr, a_mem_w_mask, a_mem_wdata);
            end
        end

        if (a_mem_cs || a_if_gnt || a_dm_gnt) begin
            tests++;
            if (gq.size() == 0) begin
                fails++;
                $display("FAIL a_grant_unexpected: cyc=%0d if_gnt=%b dm_gnt=%b addr=%h, required no grant",
                         cyc, a_if_gnt, a_dm_gnt, a_mem_addr);
            end else begin
                g = gq.pop_front();
                if (!(g.cyc == cyc && a_mem_cs && a_dm_gnt == g.dm && a_if_gnt == !g.dm &&
                      a_mem_addr == g.addr && a_mem_w_mask == g.mask && a_mem_wdata == g.wdata)) begin
                    fails++;
                    $display("FAIL a_grant: got cyc=%0d cs=%b if=%b dm=%b addr=%h mask=%h wd=%h, required cyc=%0d dm=%0d addr=%h mask=%h wd=%h",
                             cyc, a_mem_cs, a_if_gnt, a_dm_gnt, a_mem_addr, a_mem_w_mask, a_mem_wdata,
                             g.cyc, g.dm, g.addr, g.mask, g.wdata);
                end
            end
        end

        if (a_if_rvalid || a_dm_done) begin
            tests++;
            if (cq.size() == 0) begin
                fails++;
                $display("FAIL a_done_unexpected: cyc=%0d if_rvalid=%b dm_done=%b, required none",
                         cyc, a_if_rvalid, a_dm_done);
            end else begin
                d  = cq.pop_front();
                rd = d.dm ? a_dm_rdata : a_if_rdata;
                if (!(d.cyc == cyc && a_dm_done == d.dm && a_if_rvalid == !d.dm && (!d.chk || rd == d.data))) begin
                    fails++;
                    $display("FAIL a_done: got cyc=%0d rvalid=%b done=%b data=%h, required cyc=%0d dm=%0d data=%h",
                             cyc, a_if_rvalid, a_dm_done, rd, d.cyc, d.dm, d.data);
                end
            end
        end

        if (b_mem_cs || b_if_gnt || b_dm_gnt) begin
            tests++;
            if (bgq.size() == 0) begin
                fails++;
                $display("FAIL b_grant_unexpected: cyc=%0d if_gnt=%b addr=%h, required no grant", cyc, b_if_gnt, b_mem_addr);
            end else begin
                g = bgq.pop_front();
                if (!(g.cyc == cyc && b_mem_cs && b_if_gnt && !b_dm_gnt && b_mem_addr == g.addr &&
                      b_mem_w_mask == 8'd0 && b_mem_wdata == 64'd0)) begin
                    fails++;
                    $display("FAIL b_grant: got cyc=%0d cs=%b if=%b dm=%b addr=%h, required cyc=%0d addr=%h",
                             cyc, b_mem_cs, b_if_gnt, b_dm_gnt, b_mem_addr, g.cyc, g.addr);
                end
            end
        end

        if (b_if_rvalid || b_dm_done) begin
            tests++;
            if (bcq.size() == 0) begin
                fails++;
                $display("FAIL b_done_unexpected: cyc=%0d rvalid=%b done=%b, required none", cyc, b_if_rvalid, b_dm_done);
            end else begin
                d = bcq.pop_front();
                if (!(d.cyc == cyc && b_if_rvalid && !b_dm_done && b_if_rdata == d.data)) begin
                    fails++;
                    $display("FAIL b_done: got cyc=%0d rvalid=%b done=%b data=%h, required cyc=%0d data=%h",
                             cyc, b_if_rvalid, b_dm_done, b_if_rdata, d.cyc, d.data);
                end
            end
        end

        if (stim_done || cyc > 3000) begin
            if (!stim_done) begin
                tests++; fails++;
                $display("FAIL timeout: stimulus unfinished at cycle %0d, required finish by 3000", cyc);
            end
            if (gq.size() + cq.size() + bgq.size() + bcq.size() != 0) begin
                tests++; fails++;
                $display("FAIL leftover: %0d expected events never observed, required 0",
                         gq.size() + cq.size() + bgq.size() + bcq.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    // Directed stimulus; expected cycles are hand-derived from the grant cycle t.
    initial begin
        int t;
        // Requests asserted during reset must be ignored.
        a_if_req = 1'b1; a_if_addr = 32'h0000_0AAA;
        a_dm_req = 1'b1; a_dm_addr = 32'h0000_0BBB; a_dm_w_mask = 8'hFF; a_dm_wdata = '1;
        b_if_req = 1'b1; b_if_addr = 32'h0000_0CCC;
        repeat (4) tick();
        rst = 1'b0;
        a_if_req = 1'b0; a_dm_req = 1'b0; b_if_req = 1'b0;
        a_dm_w_mask = '0; a_dm_wdata = '0;
        repeat (2) tick();

        // Lone fetch read.
        tick(); t = cyc;
        a_if_req = 1'b1; a_if_addr = 32'h0000_0100;
        exp_gnt(t, 1'b0, 32'h0000_0100, 8'h00, 64'd0);
        exp_done(t + 2, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0013);
        tick(); a_if_req = 1'b0;
        repeat (3) tick();

        // Persistent contention: dm, if, dm, if, dm, if.
        tick(); t = cyc;
        a_if_req = 1'b1; a_if_addr = 32'h0000_0300;
        a_dm_req = 1'b1; a_dm_addr = 32'h0000_3000;
        for (int k = 0; k < 6; k++) begin
            exp_gnt(t + 2 * k, (k % 2) == 0, ((k % 2) == 0) ? 32'h0000_3000 : 32'h0000_0300, 8'h00, 64'd0);
            exp_done(t + 2 * k + 2, (k % 2) == 0, 1'b1,
                     memval(((k % 2) == 0) ? 32'h0000_3000 : 32'h0000_0300));
        end
        repeat (11) tick();
        a_if_req = 1'b0; a_dm_req = 1'b0;
        repeat (3) tick();

        // Contention after fetch won last: dm first, fetch back-to-back on dm_done.
        tick(); t = cyc;
        a_if_req = 1'b1; a_if_addr = 32'h0000_0200;
        a_dm_req = 1'b1; a_dm_addr = 32'h0000_2000;
        exp_gnt(t, 1'b1, 32'h0000_2000, 8'h00, 64'd0);
        exp_gnt(t + 2, 1'b0, 32'h0000_0200, 8'h00, 64'd0);
        exp_done(t + 2, 1'b1, 1'b1, memval(32'h0000_2000));
        exp_done(t + 4, 1'b0, 1'b1, memval(32'h0000_0200));
        tick(); a_dm_req = 1'b0;
        repeat (2) tick(); a_if_req = 1'b0;
        repeat (3) tick();

        // Byte-masked data write.
        tick(); t = cyc;
        a_dm_req = 1'b1; a_dm_addr = 32'h0000_0040;
        a_dm_w_mask = 8'h0F; a_dm_wdata = 64'h1122_3344_5566_7788;
        exp_gnt(t, 1'b1, 32'h0000_0040, 8'h0F, 64'h1122_3344_5566_7788);
        exp_done(t + 2, 1'b1, 1'b0, 64'd0);
        tick(); a_dm_req = 1'b0; a_dm_w_mask = '0; a_dm_wdata = '0;
        repeat (3) tick();

        // Reset one cycle after a grant abandons it; alternation state is cleared.
        tick(); t = cyc;
        a_if_req = 1'b1; a_if_addr = 32'h0000_0500;
        exp_gnt(t, 1'b0, 32'h0000_0500, 8'h00, 64'd0);
        tick(); rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0; a_if_req = 1'b0;
        repeat (3) tick();
        tick(); t = cyc;
        a_if_req = 1'b1; a_if_addr = 32'h0000_0600;
        a_dm_req = 1'b1; a_dm_addr = 32'h0000_6000;
        exp_gnt(t, 1'b1, 32'h0000_6000, 8'h00, 64'd0);
        exp_gnt(t + 2, 1'b0, 32'h0000_0600, 8'h00, 64'd0);
        exp_done(t + 2, 1'b1, 1'b1, memval(32'h0000_6000));
        exp_done(t + 4, 1'b0, 1'b1, memval(32'h0000_0600));
        tick(); a_dm_req = 1'b0;
        repeat (2) tick(); a_if_req = 1'b0;
        repeat (3) tick();

        // MEM_LAT=1: one grant per cycle, data the following cycle.
        tick(); t = cyc;
        b_if_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b_if_addr = 32'(32'h10 + 8 * k);
            bgq.push_back('{t + k, 1'b0, b_if_addr, 8'h00, 64'd0});
            bcq.push_back('{t + k + 1, 1'b0, 1'b1, memval(b_if_addr)});
            if (k < 3) tick();
        end
        tick(); b_if_req = 1'b0;
        repeat (3) tick();
        stim_done = 1'b1;
    end

endmodule
`default_nettype wire
